// File: rtl/circle_anim_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : circle_anim_ctrl                                             |
// | Description : Run/hold/idle sequencer for the 7-seg circle animation.      |
// |               Owns the speed level, emits one-cycle step pulses toward the |
// |               position tracker and scans the multi-digit display, lighting |
// |               the tracked segment ('a' or 'd') on the tracked digit.       |
// | Options     : define BLINK_HOLD_EN to blink the display while in HOLD.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module circle_anim_ctrl #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = $clog2(NUM_OF_DISPLAYS),
  parameter int STEP_BASE       = 25_000_000 / 8,
  parameter int SCAN_DIV        = 50_000,
  parameter int SPEED_RESET     = 3,
  parameter int BLINK_DIV       = 12_500_000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       speed_up_i,
  input  logic                       speed_dn_i,
  input  logic [COL_WIDTH-1:0]       curr_display_i,
  input  logic                       row_i,
  output logic                       step_o,
  output logic [NUM_OF_DISPLAYS-1:0] an_o,
  output logic [6:0]                 seg_o,
  output logic                       running_o,
  output logic [2:0]                 speed_o
);

  localparam int CNT_W  = $clog2(STEP_BASE * 8);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [NUM_OF_DISPLAYS-1:0] c_one   = NUM_OF_DISPLAYS'(1);
  localparam logic [6:0]                 c_blank = 7'h7F;
  localparam logic [6:0]                 c_seg_a = 7'b1111110;
  localparam logic [6:0]                 c_seg_d = 7'b1110111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                       r_state;
  logic                         r_running;
  logic [2:0]                   r_speed;
  logic [CNT_W-1:0]             r_step_cnt;
  logic                         r_step;
  logic [SCAN_W-1:0]            r_scan_cnt;
  logic [COL_WIDTH-1:0]         r_idx;
  logic [NUM_OF_DISPLAYS-1:0]   r_an;
  logic [6:0]                   r_seg;

  logic                         w_up_ok;
  logic                         w_dn_ok;
  logic                         w_speed_chg;
  logic [CNT_W-1:0]             w_period_m1;
  logic                         w_visible;

  // A speed request only counts when it actually moves the level; opposing requests cancel
  assign w_up_ok     = speed_up_i & ~speed_dn_i & (r_speed != 3'd7);
  assign w_dn_ok     = speed_dn_i & ~speed_up_i & (r_speed != 3'd0);
  assign w_speed_chg = w_up_ok | w_dn_ok;

  // Last count of the step period: STEP_BASE * (8 - speed) clocks
  assign w_period_m1 = CNT_W'(STEP_BASE * (8 - int'(r_speed)) - 1);

  // Control FSM; stop has priority over start, running flag tracks the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            r_state   <= ST_HOLD;
            r_running <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (stop_i) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else if (start_i) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Saturating speed level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_speed <= 3'(SPEED_RESET);
    end else if (w_up_ok) begin
      r_speed <= r_speed + 3'd1;
    end else if (w_dn_ok) begin
      r_speed <= r_speed - 3'd1;
    end
  end

  // Step period counter: advances in RUN, frozen in HOLD, cleared in IDLE or on a speed change
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_step_cnt <= '0;
      r_step     <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (w_speed_chg) begin
        r_step_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        if (r_step_cnt == w_period_m1) begin
          r_step_cnt <= '0;
          r_step     <= 1'b1;
        end else begin
          r_step_cnt <= r_step_cnt + CNT_W'(1);
        end
      end else if (r_state == ST_IDLE || stop_i) begin
        r_step_cnt <= '0;
      end
    end
  end

  // Free-running digit scan: index moves every SCAN_DIV clocks and wraps after the last digit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == COL_WIDTH'(NUM_OF_DISPLAYS - 1)) ? '0 : r_idx + COL_WIDTH'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

`ifdef BLINK_HOLD_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_vis;

  // Blink phase runs only in HOLD and restarts visible every time HOLD is entered
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != ST_HOLD) begin
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink_vis <= ~r_blink_vis;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  assign w_visible = r_blink_vis;
`else
  // Steady display in HOLD; true for every legal (non-zero) BLINK_DIV
  assign w_visible = (BLINK_DIV > 0);
`endif

  // Registered display drive: blank when idle or blinked off, else enable the scanned digit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_an  <= '1;
      r_seg <= c_blank;
    end else if (r_state == ST_IDLE || !w_visible) begin
      r_an  <= '1;
      r_seg <= c_blank;
    end else begin
      r_an  <= ~(c_one << r_idx);
      r_seg <= (r_idx == curr_display_i) ? (row_i ? c_seg_a : c_seg_d) : c_blank;
    end
  end

  assign step_o    = r_step;
  assign an_o      = r_an;
  assign seg_o     = r_seg;
  assign running_o = r_running;
  assign speed_o   = r_speed;

endmodule
`default_nettype wire

// File: tb/tb_circle_anim_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_circle_anim_ctrl                                          |
// | Description : Self-checking bench for circle_anim_ctrl: vector table,      |
// |               hand-written timing sequences and random pulses compared     |
// |               against a behavioural model each cycle.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_circle_anim_ctrl;

  localparam int N  = 6;
  localparam int CW = 3;
  localparam int SB = 4;
  localparam int SD = 2;
  localparam int BD = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0, stop_i = 1'b0, speed_up_i = 1'b0, speed_dn_i = 1'b0;
  logic [CW-1:0] curr_display_i = '0;
  logic          row_i = 1'b0;
  logic          step_o, running_o;
  logic [N-1:0]  an_o;
  logic [6:0]    seg_o;
  logic [2:0]    speed_o;

  circle_anim_ctrl #(
    .NUM_OF_DISPLAYS(N), .COL_WIDTH(CW), .STEP_BASE(SB), .SCAN_DIV(SD),
    .SPEED_RESET(3), .BLINK_DIV(BD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .speed_up_i(speed_up_i), .speed_dn_i(speed_dn_i),
    .curr_display_i(curr_display_i), .row_i(row_i),
    .step_o(step_o), .an_o(an_o), .seg_o(seg_o),
    .running_o(running_o), .speed_o(speed_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 idle / 1 run / 2 hold, elapsed run clocks in the current period
  int         m_mode, m_speed, m_elapsed, m_cyc, m_hold;
  logic       m_step;
  logic [N-1:0] m_an;
  logic [6:0] m_seg;

  typedef struct {
    logic st, sp, up, dn;
    logic run;
    int   spd;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by one clock, compare every output
  task automatic cyc(input logic st, input logic sp, input logic up, input logic dn,
                     input int cd, input logic row);
    int   idx, per, nmode;
    logic eff, vis;
    start_i = st; stop_i = sp; speed_up_i = up; speed_dn_i = dn;
    curr_display_i = CW'(cd); row_i = row;
    idx = (m_cyc / SD) % N;
    vis = 1'b1;
`ifdef BLINK_HOLD_EN
    if (m_mode == 2) vis = ((m_hold / BD) % 2) == 0;
`endif
    m_an = '1;
    m_seg = 7'h7F;
    if (m_mode != 0 && vis) begin
      m_an[idx] = 1'b0;
      if (idx == cd) m_seg = row ? 7'b1111110 : 7'b1110111;
    end
    per = SB * (8 - m_speed);
    eff = (up && !dn && m_speed < 7) || (dn && !up && m_speed > 0);
    m_step = 1'b0;
    if (eff) m_elapsed = 0;
    else if (m_mode == 1) begin
      if (m_elapsed + 1 == per) begin m_elapsed = 0; m_step = 1'b1; end
      else m_elapsed++;
    end else if (m_mode == 0 || sp) m_elapsed = 0;
    if (eff) m_speed = up ? m_speed + 1 : m_speed - 1;
    m_hold = (m_mode == 2) ? m_hold + 1 : 0;
    case (m_mode)
      0:       nmode = (st && !sp) ? 1 : 0;
      1:       nmode = sp ? 2 : 1;
      default: nmode = sp ? 0 : (st ? 1 : 2);
    endcase
    m_mode = nmode;
    m_cyc++;
    @(posedge clk_i); #1;
    chk("step_o", step_o, m_step);
    chk("running_o", running_o, (m_mode == 1));
    chk("speed_o", speed_o, m_speed);
    chk("an_o", an_o, m_an);
    chk("seg_o", seg_o, m_seg);
  endtask

  task automatic idle(input int cd, input logic row);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, cd, row);
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    start_i = 1'b0; stop_i = 1'b0; speed_up_i = 1'b0; speed_dn_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_mode = 0; m_speed = 3; m_elapsed = 0; m_cyc = 0; m_hold = 0;
    m_step = 1'b0; m_an = '1; m_seg = 7'h7F;
    chk("rst_speed", speed_o, 3);
    chk("rst_an", an_o, 6'h3F);
    chk("rst_seg", seg_o, 7'h7F);
    chk("rst_step", step_o, 0);
    chk("rst_running", running_o, 0);
  endtask

  initial begin
    int steps[$];
    int nstep, first, j, lit0[$];

    // Vector table: control pulses and the run flag / speed level expected afterwards
    vecs[0]  = '{1, 0, 0, 0, 1, 3};
    vecs[1]  = '{0, 0, 1, 0, 1, 4};
    vecs[2]  = '{0, 0, 1, 1, 1, 4};
    vecs[3]  = '{0, 0, 0, 1, 1, 3};
    vecs[4]  = '{1, 0, 0, 0, 1, 3};
    vecs[5]  = '{0, 1, 0, 0, 0, 3};
    vecs[6]  = '{0, 0, 0, 1, 0, 2};
    vecs[7]  = '{1, 0, 0, 0, 1, 2};
    vecs[8]  = '{1, 1, 0, 0, 0, 2};
    vecs[9]  = '{0, 1, 0, 0, 0, 2};
    vecs[10] = '{0, 1, 0, 0, 0, 2};
    vecs[11] = '{0, 0, 0, 1, 0, 1};
    vecs[12] = '{0, 0, 0, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 1, 0, 0};
    vecs[14] = '{1, 1, 0, 0, 0, 0};
    vecs[15] = '{1, 0, 0, 0, 1, 0};

    // Reset, then a quiet idle stretch with no step pulse
    do_reset(3);
    nstep = 0;
    for (int i = 0; i < 100; i++) begin
      idle(i % 8, i[0]);
      if (step_o) nstep++;
    end
    chk("idle_no_step", nstep, 0);

    // Table-driven control vectors
    do_reset(3);
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].st, vecs[i].sp, vecs[i].up, vecs[i].dn, $urandom_range(0, 7), $urandom_range(0, 1));
      chk("vec_running", running_o, vecs[i].run);
      chk("vec_speed", speed_o, vecs[i].spd);
    end

    // Step timing from start: pulses at T+21, T+41, T+61
    do_reset(3);
    cyc(1, 0, 0, 0, 0, 1);
    chk("start_running", running_o, 1);
    for (int i = 2; i <= 70; i++) begin
      idle(0, 1);
      if (step_o) steps.push_back(i);
    end
    chk("step_count", steps.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("step_time", (steps.size() > i) ? steps[i] : -1, 21 + 20 * i);

    // Speed saturation: six ups from 3 -> 7, period becomes 4
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 1);
    chk("speed_sat", speed_o, 7);
    steps.delete();
    for (int i = 0; i < 20; i++) begin
      idle(0, 1);
      if (step_o) steps.push_back(i);
    end
    chk("fast_period", (steps.size() >= 2) ? steps[1] - steps[0] : -1, 4);
    cyc(0, 0, 1, 1, 0, 1);
    chk("up_dn_same", speed_o, 7);

    // Hold and resume: frozen at count 10, next step 11 cycles after resume
    do_reset(3);
    cyc(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 9; i++) idle(3, 0);
    cyc(0, 1, 0, 0, 3, 0);
    nstep = 0;
    for (int i = 0; i < 50; i++) begin
      idle(3, 0);
      if (step_o) nstep++;
    end
    chk("hold_no_step", nstep, 0);
    cyc(1, 0, 0, 0, 3, 0);
    first = step_o ? 1 : -1;
    j = 1;
    while (first < 0 && j < 40) begin
      idle(3, 0);
      j++;
      if (step_o) first = j;
    end
    chk("resume_step", first, 11);
    cyc(0, 1, 0, 0, 3, 0);
    cyc(0, 1, 0, 0, 3, 0);
    idle(3, 0);
    idle(3, 0);
    chk("idle_an_blank", an_o, 6'h3F);
    chk("idle_seg_blank", seg_o, 7'h7F);

    // Display: digit 2 lit with 'a' then 'd'; scan index period 12
    do_reset(3);
    cyc(1, 0, 0, 0, 2, 1);
    for (int i = 0; i < 48; i++) begin
      idle(2, (i < 24));
      if (an_o == 6'b111011)
        chk("seg_on_digit2", seg_o, (i < 24) ? 7'b1111110 : 7'b1110111);
      else
        chk("seg_off", seg_o, 7'h7F);
      if (an_o == 6'b111110) lit0.push_back(i);
    end
    chk("scan_wrap", (lit0.size() >= 3) ? lit0[2] - lit0[0] : -1, 12);
    for (int i = 0; i < 12; i++) idle(6 + i % 2, 1);

    // start and stop together in IDLE: stays idle
    do_reset(3);
    cyc(1, 1, 0, 0, 0, 1);
    chk("start_stop_idle", running_o, 0);
    idle(0, 1);
    chk("start_stop_blank", an_o, 6'h3F);

`ifdef BLINK_HOLD_EN
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    nstep = 0;
    for (int i = 0; i < 16; i++) begin
      idle(0, 1);
      if (an_o != 6'h3F) nstep++;
    end
    chk("blink_lit_cycles", nstep, 8);
`endif

    // Random pulses against the model
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset(1 + (i % 3));
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 7), $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
